// File: rtl/sampler_pkg.sv
// sampler_pkg
// Constants and the compactor state type shared by the rejection-sampler
// back end. The lane count, coefficient width, staging depth and polynomial
// length live here so the compactor and its lane helper agree on them.
//
// Also defined here:
//   - derived counter widths;
//   - cmp_state_t, the compactor FSM state enum.

package sampler_pkg;

    localparam int LANES     = 4;
    localparam int CAND_BITS = 12;
    localparam int N_COEFF   = 256;
    localparam int BUF_DEPTH = 8;

    // Ingest counter must hold N_COEFF itself (it saturates there).
    localparam int ING_W  = $clog2(N_COEFF + 1);
    // Occupancy must hold BUF_DEPTH itself.
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    // Per-beat lane count, 0..LANES.
    localparam int LCNT_W = $clog2(LANES + 1);
    // Offset of a lane inside one beat, 0..LANES-1.
    localparam int OFF_W  = $clog2(LANES);
    localparam int IDX_W  = $clog2(N_COEFF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cmp_state_t;

endpackage

// File: rtl/lane_compact.sv
// lane_compact
// Combinational prefix popcount over the accept mask. For every accepted
// lane it gives the offset at which that lane lands in the dense stream,
// and it drops trailing accepted lanes once the polynomial quota is
// reached.
//
// Ports:
//   i_acc        in   LANES    accept mask, bit i qualifies lane i
//   i_ingested   in   ING_W    coefficients already taken this polynomial
//   o_take       out  LANES    lanes that are actually written
//   o_offset     out  LANES*OFF_W  lane i target offset at [i*OFF_W +: OFF_W]
//   o_taken_cnt  out  LCNT_W   number of lanes written (after the cap)

module lane_compact
    import sampler_pkg::*;
(
    input  logic [LANES-1:0]       i_acc,
    input  logic [ING_W-1:0]       i_ingested,
    output logic [LANES-1:0]       o_take,
    output logic [LANES*OFF_W-1:0] o_offset,
    output logic [LCNT_W-1:0]      o_taken_cnt
);

    logic [ING_W-1:0]  w_remaining;
    logic [LCNT_W-1:0] w_run;

    assign w_remaining = ING_W'(N_COEFF) - i_ingested;

    // Truncation only ever removes the tail of the accepted set, so the
    // running count of taken lanes is also the offset of each taken lane.
    always_comb begin
        o_take   = '0;
        o_offset = '0;
        w_run    = '0;
        for (int i = 0; i < LANES; i++) begin
            o_offset[i*OFF_W +: OFF_W] = w_run[OFF_W-1:0];
            if (i_acc[i] && (ING_W'(w_run) < w_remaining)) begin
                o_take[i] = 1'b1;
                w_run     = w_run + LCNT_W'(1);
            end
        end
        o_taken_cnt = w_run;
    end

endmodule

// File: rtl/sample_compactor.sv
// sample_compactor
// Packs the accepted lanes of each sampler beat into a dense, in-order
// coefficient stream. It counts exactly N_COEFF coefficients per
// polynomial, discards surplus accepted lanes, and flags the last one.
// The output side is AXI-stream style with backpressure.
//
// Optional feature: define SAMPLE_COMPACTOR_STATS_EN to add the
// stat_rejected / stat_dropped counters and their ports.
//
// Ports:
//   clk            in   1     clock
//   rst            in   1     synchronous active-high reset
//   start          in   1     begin a polynomial (honoured in IDLE/DONE)
//   in_valid       in   1     input beat valid
//   in_acc         in   LANES accept mask
//   in_data        in   LANES*CAND_BITS  lane i at [i*CAND_BITS +: CAND_BITS]
//   in_ready       out  1     a full beat fits in the buffer
//   out_tdata      out  CAND_BITS  head coefficient
//   out_tvalid     out  1     buffer not empty
//   out_tready     in   1     consumer ready
//   out_tlast      out  1     current coefficient is index N_COEFF-1
//   out_idx        out  IDX_W index of out_tdata
//   done           out  1     pulse after the last handshake
//   stat_rejected  out  16    (stats build) cleared lanes in taken beats
//   stat_dropped   out  8     (stats build) accepted lanes lost to the cap
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | after reset, nothing accepted
// FILL     | ingesting beats until N_COEFF coefficients taken
// DRAIN    | quota reached, emptying the buffer
// DONE     | last coefficient handed off, waiting for start

module sample_compactor
    import sampler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [LANES-1:0]           in_acc,
    input  logic [LANES*CAND_BITS-1:0] in_data,
    output logic                       in_ready,
    output logic [CAND_BITS-1:0]       out_tdata,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic                       out_tlast,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       done
`ifdef SAMPLE_COMPACTOR_STATS_EN
    ,
    output logic [15:0]                stat_rejected,
    output logic [7:0]                 stat_dropped
`endif
);

    cmp_state_t           r_state;
    cmp_state_t           w_state_next;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_next;
    logic [ING_W-1:0]     r_ingested;
    logic [ING_W-1:0]     w_ing_sum;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_done;
    logic [CAND_BITS-1:0] r_buf      [BUF_DEPTH];
    logic [CAND_BITS-1:0] w_buf_next [BUF_DEPTH];

    logic                 w_take;
    logic                 w_pop;
    logic                 w_last_hs;
    logic                 w_start_ok;
    logic [CNT_W-1:0]     w_wr_base;

    logic [LANES-1:0]       w_lane_take;
    logic [LANES*OFF_W-1:0] w_lane_off;
    logic [LCNT_W-1:0]      w_taken_cnt;

    lane_compact u_lane_compact (
        .i_acc       (in_acc),
        .i_ingested  (r_ingested),
        .o_take      (w_lane_take),
        .o_offset    (w_lane_off),
        .o_taken_cnt (w_taken_cnt)
    );

    // Registered occupancy only: a pop in the same cycle does not open room.
    assign in_ready   = (r_state == ST_FILL) &&
                        (({1'b0, r_count} + (CNT_W+1)'(LANES)) <= (CNT_W+1)'(BUF_DEPTH));
    assign out_tvalid = (r_count != '0);
    assign out_tdata  = r_buf[0];
    assign out_idx    = r_out_idx;
    assign out_tlast  = out_tvalid && (r_out_idx == IDX_W'(N_COEFF - 1));
    assign done       = r_done;

    assign w_take     = in_valid && in_ready;
    assign w_pop      = out_tvalid && out_tready;
    assign w_last_hs  = w_pop && out_tlast;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_wr_base  = r_count - CNT_W'(w_pop);
    assign w_ing_sum  = r_ingested + ING_W'(w_taken_cnt);

    assign w_count_next = r_count
                        + (w_take ? CNT_W'(w_taken_cnt) : CNT_W'(0))
                        - CNT_W'(w_pop);

    // Shift on pop first, then land new lanes just behind the surviving
    // entries so a simultaneous push and pop stays in order.
    always_comb begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
            w_buf_next[j] = r_buf[j];
        end
        if (w_pop) begin
            for (int j = 0; j < BUF_DEPTH - 1; j++) begin
                w_buf_next[j] = r_buf[j+1];
            end
            w_buf_next[BUF_DEPTH-1] = '0;
        end
        if (w_take) begin
            for (int j = 0; j < BUF_DEPTH; j++) begin
                for (int i = 0; i < LANES; i++) begin
                    if (w_lane_take[i] &&
                        ((w_wr_base + CNT_W'(w_lane_off[i*OFF_W +: OFF_W])) == CNT_W'(j))) begin
                        w_buf_next[j] = in_data[i*CAND_BITS +: CAND_BITS];
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_next = ST_FILL;
            ST_FILL:  if (w_take && (w_ing_sum == ING_W'(N_COEFF))) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_last_hs) w_state_next = ST_DONE;
            ST_DONE:  if (w_start_ok) w_state_next = ST_FILL;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_ingested <= '0;
            r_out_idx  <= '0;
            r_done     <= 1'b0;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                r_buf[j] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_done  <= w_last_hs;
            for (int j = 0; j < BUF_DEPTH; j++) begin
                r_buf[j] <= w_buf_next[j];
            end
            if (w_start_ok) begin
                r_ingested <= '0;
            end else if (w_take) begin
                r_ingested <= w_ing_sum;
            end
            if (w_start_ok) begin
                r_out_idx <= '0;
            end else if (w_pop) begin
                r_out_idx <= r_out_idx + IDX_W'(1);
            end
        end
    end

`ifdef SAMPLE_COMPACTOR_STATS_EN
    logic [15:0]       r_stat_rej;
    logic [7:0]        r_stat_drop;
    logic [LCNT_W-1:0] w_acc_cnt;
    logic [16:0]       w_rej_sum;
    logic [8:0]        w_drop_sum;

    assign w_acc_cnt  = LCNT_W'($countones(in_acc));
    assign w_rej_sum  = {1'b0, r_stat_rej}  + 17'(LCNT_W'(LANES) - w_acc_cnt);
    assign w_drop_sum = {1'b0, r_stat_drop} + 9'(w_acc_cnt - w_taken_cnt);

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_stat_rej  <= '0;
            r_stat_drop <= '0;
        end else if (w_take) begin
            r_stat_rej  <= w_rej_sum[16]  ? 16'hFFFF : w_rej_sum[15:0];
            r_stat_drop <= w_drop_sum[8]  ? 8'hFF    : w_drop_sum[7:0];
        end
    end

    assign stat_rejected = r_stat_rej;
    assign stat_dropped  = r_stat_drop;
`endif

endmodule

// File: doc/sample_compactor.md
# sample_compactor

Downstream stage of the rejection sampler. It takes the sampler's per-cycle lane bundle (up to LANES candidates plus an accept mask) and compacts the accepted lanes into a dense, in-order coefficient stream. It counts exactly N_COEFF coefficients per polynomial, drops any surplus accepted lanes, and marks the final coefficient. It sits between the sampler and the polynomial RAM / NTT input and presents an AXI-stream-style output with backpressure.

## Interface
- LANES, 4: candidate lanes per input beat.
- CAND_BITS, 12: coefficient width.
- BUF_DEPTH, 8: staging buffer capacity in coefficients; must be ≥ 2*LANES.
- N_COEFF, 256: coefficients per polynomial.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new polynomial (honoured only in IDLE or DONE).
- in_valid  in  1  input beat valid; driven by the sampler's sample_tvalid.
- in_acc  in  LANES  accept mask; bit i qualifies lane i.
- in_data  in  LANES*CAND_BITS  lane i is at [i*CAND_BITS +: CAND_BITS]; lanes are not compacted on input.
- in_ready  out  1  buffer can absorb a full beat; gates the upstream random source.
- out_tdata  out  CAND_BITS  coefficient.
- out_tvalid  out  1  coefficient valid.
- out_tready  in  1  consumer ready.
- out_tlast  out  1  asserted with coefficient N_COEFF-1.
- out_idx  out  $clog2(N_COEFF)  index of the current out_tdata.
- done  out  1  one-cycle pulse after the last coefficient handshakes.

## Operation
- States:
  - IDLE: entered on reset.
  - FILL: start moves IDLE→FILL and DONE→FILL.
  - DRAIN: FILL→DRAIN when the ingested count reaches N_COEFF.
  - DONE: DRAIN→DONE on the handshake of the tlast beat.
- Ingest: a beat is taken when in_valid && in_ready. Accepted lanes are appended in ascending lane order (lane 0 first).
- Cap: ingest stops once N_COEFF coefficients have been taken. Accepted lanes beyond the cap in the same beat are discarded. Beats arriving in DRAIN, DONE or IDLE are ignored.
- in_ready = (state==FILL) && (count + LANES ≤ BUF_DEPTH). count is the registered occupancy; a same-cycle pop is not credited.
- Output: head of the buffer. out_tvalid = (count ≠ 0). A pop occurs when out_tvalid && out_tready. out_idx increments per pop and wraps to 0 at start.
- Occupancy update per cycle: count_next = count + popcount(taken lanes) − pop. Simultaneous push and pop is legal. The buffer shifts on pop and writes at offset count − pop.
- Arithmetic: count is $clog2(BUF_DEPTH+1) bits. The ingest counter is $clog2(N_COEFF+1) bits and saturates at N_COEFF.
- start in FILL or DRAIN is ignored.
- in_acc = 0 beats consume a handshake and produce nothing.

## Timing
- Reset values: in_ready 0, out_tvalid 0, out_tdata 0, out_tlast 0, out_idx 0, done 0. Buffer and counters are cleared.
- Reset mid-operation discards buffered coefficients. All outputs take their reset values the cycle after rst is sampled high.
- in_ready rises the cycle after start.
- Latency: a coefficient accepted at edge k can appear on out_tdata after edge k (registered path, 1 cycle).
- out_tdata, out_tlast and out_idx are held stable while out_tvalid && !out_tready.
- Throughput: 1 coefficient per cycle out; up to LANES in.
- done pulses in the cycle after the tlast handshake; the state is then DONE.

## Configuration
- SAMPLE_COMPACTOR_STATS_EN defined: adds outputs stat_rejected (16 bits, total cleared lanes in taken beats) and stat_dropped (8 bits, accepted lanes discarded by the cap). Both clear on start and saturate.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package sampler_pkg holds the constants N_COEFF, CAND_BITS and LANES, and the state enum typedef cmp_state_t.
- One sub-module, lane_compact: combinational prefix popcount over in_acc. It yields each lane's target offset and the taken-lane count, including cap truncation.

## Test plan
- Full accept: start; in_acc=4'hF with lanes {4,3,2,1} (lane 0 = 1) → out stream 1,2,3,4, out_idx 0..3.
- Sparse accept: in_acc=4'b1010 with lanes {0xD,0xC,0xB,0xA} → emits 0xB then 0xD only.
- Backpressure: out_tready=0 for 10 cycles while feeding full beats → in_ready drops once count > 4; out_tdata stays stable; no loss or duplication after release.
- Cap: after 254 coefficients ingested, beat in_acc=4'hF → only lanes 0 and 1 taken; out_tlast on idx 255; done pulse; in_ready=0. With SAMPLE_COMPACTOR_STATS_EN, stat_dropped=2.
- Reset mid-FILL with count=5 → next cycle out_tvalid=0, in_ready=0, state IDLE; a subsequent start restarts at idx 0.
- Zero-accept beats: in_acc=0 for 20 beats → no output; ingest count unchanged.
